// File: rtl/sysbus_pkg.sv
// Shared definitions for the system-bus arbiter: requester indices and FSM state encoding.
package sysbus_pkg;

    localparam int REQ_CPU  = 0;
    localparam int REQ_DMA0 = 1;
    localparam int REQ_DMA1 = 2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_TURN  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sysbus_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from ptr+1, wrapping mod NREQ.
module rr_pick #(
    parameter int NREQ = 3,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] pick,
    output logic [IW-1:0]   pick_id,
    output logic            any
);

    always_comb begin
        int idx;
        logic [IW-1:0] sel;
        pick    = '0;
        pick_id = '0;
        any     = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int i = 1; i <= NREQ; i++) begin
            // Explicit wrap so non-power-of-two NREQ never indexes past the last requester.
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            sel = IW'(idx);
            if (!any && req[sel]) begin
                any       = 1'b1;
                pick[sel] = 1'b1;
                pick_id   = sel;
            end
        end
    end

endmodule

// File: rtl/sysbus_arbiter.sv
// Round-robin bus arbiter with registered one-hot grant, turnaround gap between owners
// and a burst limit that preempts an unlocked owner when others are waiting.
module sysbus_arbiter
    import sysbus_pkg::*;
#(
    parameter int NREQ        = 3,
    parameter int MAX_BURST   = 16,
    parameter int TURN_CYCLES = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NREQ-1:0]                       req,
    input  logic [NREQ-1:0]                       lock,
    output logic [NREQ-1:0]                       gnt,
    output logic                                  gnt_valid,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] gnt_id,
    output logic                                  preempt,
    output arb_state_t                            dbg_state
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam logic [CW-1:0] BURST_LAST = CW'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);
    localparam logic [TW-1:0] TURN_LAST  = TW'(TURN_CYCLES - 1);

    arb_state_t      state, state_nx;
    logic [NREQ-1:0] gnt_nx;
    logic [IW-1:0]   gnt_id_nx;
    logic            preempt_nx;
    logic [CW-1:0]   burst_cnt, burst_nx;
    logic [TW-1:0]   turn_cnt, turn_nx;
    logic [IW-1:0]   rr_ptr, rr_nx;

    logic [NREQ-1:0] pick;
    logic [IW-1:0]   pick_id;
    logic            pick_any;
    logic            others;
    logic            preempt_hit;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req     (req),
        .ptr     (rr_ptr),
        .pick    (pick),
        .pick_id (pick_id),
        .any     (pick_any)
    );

    assign others      = |(req & ~gnt);
    assign preempt_hit = (MAX_BURST != 0) && (burst_cnt == BURST_LAST) && !lock[gnt_id] && others;
    assign gnt_valid   = |gnt;
    assign dbg_state   = state;

    always_comb begin
        state_nx   = state;
        gnt_nx     = gnt;
        gnt_id_nx  = gnt_id;
        preempt_nx = 1'b0;
        burst_nx   = burst_cnt;
        turn_nx    = turn_cnt;
        rr_nx      = rr_ptr;
        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_nx  = ARB_GRANT;
                    gnt_nx    = pick;
                    gnt_id_nx = pick_id;
                    rr_nx     = pick_id;
                    burst_nx  = '0;
                end
            end
            ARB_GRANT: begin
                // A release beats a preemption that would fire in the same cycle.
                if (!req[gnt_id]) begin
                    state_nx = ARB_TURN;
                    gnt_nx   = '0;
                    turn_nx  = '0;
                end else if (preempt_hit) begin
                    state_nx   = ARB_TURN;
                    gnt_nx     = '0;
                    turn_nx    = '0;
                    preempt_nx = 1'b1;
                end else if (burst_cnt != BURST_LAST) begin
                    burst_nx = burst_cnt + 1'b1;
                end
            end
            ARB_TURN: begin
                if (turn_cnt == TURN_LAST) begin
                    if (pick_any) begin
                        state_nx  = ARB_GRANT;
                        gnt_nx    = pick;
                        gnt_id_nx = pick_id;
                        rr_nx     = pick_id;
                        burst_nx  = '0;
                    end else begin
                        state_nx = ARB_IDLE;
                    end
                end else begin
                    turn_nx = turn_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = ARB_IDLE;
                gnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARB_IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            preempt   <= 1'b0;
            burst_cnt <= '0;
            turn_cnt  <= '0;
            rr_ptr    <= IW'(NREQ - 1);
        end else begin
            state     <= state_nx;
            gnt       <= gnt_nx;
            gnt_id    <= gnt_id_nx;
            preempt   <= preempt_nx;
            burst_cnt <= burst_nx;
            turn_cnt  <= turn_nx;
            rr_ptr    <= rr_nx;
        end
    end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: two instances (burst limits 4 and 2) share one stimulus stream.
module tb_sysbus_arbiter;
    import sysbus_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [2:0] req;
    logic [2:0] lock;

    logic [2:0] gnt_a, gnt_b;
    logic       gnt_valid_a, gnt_valid_b;
    logic [1:0] gnt_id_a, gnt_id_b;
    logic       preempt_a, preempt_b;
    arb_state_t state_a, state_b;

    int total = 0;
    int bad   = 0;
    logic [6:0] exp_q[$];

    sysbus_arbiter #(.NREQ(3), .MAX_BURST(4), .TURN_CYCLES(1)) dut_a (
        .clk(clk), .reset(reset), .req(req), .lock(lock),
        .gnt(gnt_a), .gnt_valid(gnt_valid_a), .gnt_id(gnt_id_a),
        .preempt(preempt_a), .dbg_state(state_a)
    );

    sysbus_arbiter #(.NREQ(3), .MAX_BURST(2), .TURN_CYCLES(1)) dut_b (
        .clk(clk), .reset(reset), .req(req), .lock(lock),
        .gnt(gnt_b), .gnt_valid(gnt_valid_b), .gnt_id(gnt_id_b),
        .preempt(preempt_b), .dbg_state(state_b)
    );

    // One cycle: drive inputs at negedge, queue the output expected after the next posedge, then check it.
    task automatic step(input string tag, input bit sel, input logic rst,
                        input logic [2:0] r, input logic [2:0] l,
                        input logic [2:0] eg, input logic [1:0] eid, input logic ep);
        logic [6:0] got;
        logic [6:0] exp;
        @(negedge clk);
        reset = rst;
        req   = r;
        lock  = l;
        exp_q.push_back({|eg, eg, eid, ep});
        @(posedge clk);
        #1;
        got = sel ? {gnt_valid_b, gnt_b, gnt_id_b, preempt_b}
                  : {gnt_valid_a, gnt_a, gnt_id_a, preempt_a};
        exp = exp_q.pop_front();
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got {valid,gnt,id,pre}=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag, input arb_state_t got, input arb_state_t es);
        total++;
        assert (got === es) else begin
            bad++;
            $error("FAIL %s: got state=%0d expected=%0d", tag, got, es);
        end
    endtask

    // Structural invariants on both instances every cycle out of reset.
    always @(posedge clk) begin
        #2;
        if (!reset) begin
            total++;
            assert ($onehot0(gnt_a) && $onehot0(gnt_b)
                    && (!gnt_valid_a || gnt_a == (3'b001 << gnt_id_a))
                    && (!gnt_valid_b || gnt_b == (3'b001 << gnt_id_b))) else begin
                bad++;
                $error("FAIL invariant: gnt_a=%b id_a=%0d gnt_b=%b id_b=%0d expected one-hot matching id",
                       gnt_a, gnt_id_a, gnt_b, gnt_id_b);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] eg;
        int o;
        reset = 1'b1;
        req   = 3'b000;
        lock  = 3'b000;

        step("rst0", 0, 1, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
        step("rst1", 0, 1, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
        check_state("rst_state", state_a, ARB_IDLE);

        // Single CPU request, release, turnaround, back to idle.
        step("t1_gnt",  0, 0, 3'b001, 3'b000, 3'b001, 2'd0, 1'b0);
        step("t1_hold", 0, 0, 3'b001, 3'b000, 3'b001, 2'd0, 1'b0);
        step("t1_hold", 0, 0, 3'b001, 3'b000, 3'b001, 2'd0, 1'b0);
        step("t1_rel",  0, 0, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
        check_state("t1_turn_state", state_a, ARB_TURN);
        step("t1_idle", 0, 0, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
        check_state("t1_idle_state", state_a, ARB_IDLE);

        // Tie after reset goes to CPU; handover to DMA0 after one gap cycle; id held when idle.
        step("t2_rst",   0, 1, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
        step("t2_gnt0",  0, 0, 3'b011, 3'b000, 3'b001, 2'd0, 1'b0);
        step("t2_hold0", 0, 0, 3'b011, 3'b000, 3'b001, 2'd0, 1'b0);
        step("t2_turn",  0, 0, 3'b010, 3'b000, 3'b000, 2'd0, 1'b0);
        step("t2_gnt1",  0, 0, 3'b010, 3'b000, 3'b010, 2'd1, 1'b0);
        step("t2_hold1", 0, 0, 3'b010, 3'b000, 3'b010, 2'd1, 1'b0);
        step("t2_rel",   0, 0, 3'b000, 3'b000, 3'b000, 2'd1, 1'b0);
        step("t2_idle",  0, 0, 3'b000, 3'b000, 3'b000, 2'd1, 1'b0);

        // Burst limit 4: DMA0 preempted after four grant cycles, CPU gets the bus next.
        step("t3_rst",  0, 1, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
        step("t3_gnt1", 0, 0, 3'b010, 3'b000, 3'b010, 2'd1, 1'b0);
        for (int i = 0; i < 3; i++)
            step("t3_burst", 0, 0, 3'b011, 3'b000, 3'b010, 2'd1, 1'b0);
        step("t3_preempt", 0, 0, 3'b011, 3'b000, 3'b000, 2'd1, 1'b1);
        step("t3_gnt0",    0, 0, 3'b011, 3'b000, 3'b001, 2'd0, 1'b0);
        step("t3_rel",     0, 0, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
        step("t3_idle",    0, 0, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);

        // Lock holds off preemption; dropping it preempts at once with the counter saturated.
        step("t4_rst",  0, 1, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
        step("t4_gnt1", 0, 0, 3'b010, 3'b000, 3'b010, 2'd1, 1'b0);
        for (int i = 0; i < 22; i++)
            step("t4_lock", 0, 0, 3'b011, 3'b010, 3'b010, 2'd1, 1'b0);
        step("t4_unlock", 0, 0, 3'b011, 3'b000, 3'b000, 2'd1, 1'b1);
        step("t4_gnt0",   0, 0, 3'b011, 3'b000, 3'b001, 2'd0, 1'b0);
        step("t4_rel",    0, 0, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
        step("t4_idle",   0, 0, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);

        // Owner drops its request on the cycle preemption would fire: plain release, no pulse.
        step("ts_rst",  0, 1, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
        step("ts_gnt1", 0, 0, 3'b010, 3'b000, 3'b010, 2'd1, 1'b0);
        for (int i = 0; i < 3; i++)
            step("ts_burst", 0, 0, 3'b011, 3'b000, 3'b010, 2'd1, 1'b0);
        step("ts_drop", 0, 0, 3'b001, 3'b000, 3'b000, 2'd1, 1'b0);
        step("ts_gnt0", 0, 0, 3'b001, 3'b000, 3'b001, 2'd0, 1'b0);
        step("ts_rel",  0, 0, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
        step("ts_idle", 0, 0, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);

        // Waiting request withdrawn during the gap: preempted owner wins again.
        step("t7_rst",  0, 1, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
        step("t7_gnt1", 0, 0, 3'b010, 3'b000, 3'b010, 2'd1, 1'b0);
        for (int i = 0; i < 3; i++)
            step("t7_burst", 0, 0, 3'b011, 3'b000, 3'b010, 2'd1, 1'b0);
        step("t7_preempt",  0, 0, 3'b011, 3'b000, 3'b000, 2'd1, 1'b1);
        step("t7_withdraw", 0, 0, 3'b010, 3'b000, 3'b010, 2'd1, 1'b0);
        step("t7_rel",      0, 0, 3'b000, 3'b000, 3'b000, 2'd1, 1'b0);
        step("t7_idle",     0, 0, 3'b000, 3'b000, 3'b000, 2'd1, 1'b0);

        // Reset mid-grant wins over req; afterwards rr_ptr is back at 2 so DMA0 beats DMA1.
        step("t6_rst0",  0, 1, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
        step("t6_gnt1",  0, 0, 3'b010, 3'b000, 3'b010, 2'd1, 1'b0);
        step("t6_hold1", 0, 0, 3'b010, 3'b000, 3'b010, 2'd1, 1'b0);
        step("t6_rst",   0, 1, 3'b010, 3'b000, 3'b000, 2'd0, 1'b0);
        check_state("t6_rst_state", state_a, ARB_IDLE);
        step("t6_regnt", 0, 0, 3'b110, 3'b000, 3'b010, 2'd1, 1'b0);
        step("t6_rel",   0, 0, 3'b000, 3'b000, 3'b000, 2'd1, 1'b0);
        step("t6_idle",  0, 0, 3'b000, 3'b000, 3'b000, 2'd1, 1'b0);

        // Burst limit 2, all requesting: rotation 0,1,2,0 with two-cycle grants and one-cycle gaps.
        step("t5_rst", 1, 1, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            o  = k % 3;
            eg = 3'(1 << o);
            step("t5_gnt",     1, 0, 3'b111, 3'b000, eg,     2'(o), 1'b0);
            step("t5_hold",    1, 0, 3'b111, 3'b000, eg,     2'(o), 1'b0);
            step("t5_preempt", 1, 0, 3'b111, 3'b000, 3'b000, 2'(o), 1'b1);
        end
        step("t5_idle", 1, 0, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
        check_state("t5_idle_state", state_b, ARB_IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
